// File: rtl/etpu_io_streamer.sv
// etpu_io_streamer
// Output stage behind the eTPU systolic array. Accepts one N x N frame of
// signed accumulators per handshake, saturates every word to signed 16 bits
// and streams the words one at a time onto the user GPIO bank.
// Each word is held with io_en high for HOLD cycles, followed by one gap cycle.
//
// Ports:
//   wb_clk_i    in   system clock
//   wb_rst_i    in   asynchronous active-high reset
//   res_valid   in   result frame available
//   res_ready   out  streamer can accept a frame (combinational)
//   res_data    in   flattened frame, word k at [k*ACC_W +: ACC_W]
//   abort       in   synchronous frame cancel
//   io_data     out  saturated word            (mprj_io[23:8])
//   io_idx      out  index of the current word (mprj_io[27:24])
//   io_en       out  word-valid strobe         (mprj_io[28])
//   io_active   out  frame in progress         (mprj_io[29])
//   done_pulse  out  one-cycle end-of-frame pulse
//
// All GPIO-facing outputs are registered from the current FSM state, so
// they trail the state by one cycle: a handshake at edge T shows word 0
// after edge T+1.
module etpu_io_streamer #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int HOLD  = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [N*N*ACC_W-1:0]   res_data,
  input  logic                   abort,
  output logic [15:0]            io_data,
  output logic [3:0]             io_idx,
  output logic                   io_en,
  output logic                   io_active,
  output logic                   done_pulse
);

  localparam int NN = N * N;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_k, w_k_next;
  logic [7:0]  r_hold, w_hold_next;

  logic [15:0] r_io_data, w_io_data_next;
  logic [3:0]  r_io_idx, w_io_idx_next;
  logic        r_io_en, w_io_en_next;
  logic        r_io_active, w_io_active_next;
  logic        r_done, w_done_next;

  logic [15:0] r_buf [NN];
  logic [15:0] w_sat [NN];
  logic        w_hs;

  assign res_ready = (r_state == IDLE) && !abort;
  assign w_hs      = res_valid && res_ready;

  // Saturate every input word to signed 16 bits and capture on handshake.
  // A word fits when all bits from 15 upward are identical (pure sign
  // extension); otherwise its sign picks the clamp value.
  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_sat
      logic [ACC_W-16:0] w_top;
      assign w_top = res_data[gi*ACC_W+15 +: ACC_W-15];
      assign w_sat[gi] = ((&w_top) || !(|w_top)) ? res_data[gi*ACC_W +: 16]
                       : (w_top[ACC_W-16] ? 16'h8000 : 16'h7FFF);

      always_ff @(posedge wb_clk_i) begin
        if (w_hs) begin
          r_buf[gi] <= w_sat[gi];
        end
      end
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_hold      <= '0;
      r_io_data   <= '0;
      r_io_idx    <= '0;
      r_io_en     <= 1'b0;
      r_io_active <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_hold      <= w_hold_next;
      r_io_data   <= w_io_data_next;
      r_io_idx    <= w_io_idx_next;
      r_io_en     <= w_io_en_next;
      r_io_active <= w_io_active_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_next     = r_state;
    w_k_next         = r_k;
    w_hold_next      = r_hold;
    w_io_data_next   = r_io_data;
    w_io_idx_next    = r_io_idx;
    w_io_en_next     = 1'b0;
    w_io_active_next = 1'b0;
    w_done_next      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_next = SHOW;
          w_k_next     = '0;
          w_hold_next  = '0;
        end
      end
      SHOW: begin
        w_io_en_next     = 1'b1;
        w_io_active_next = 1'b1;
        w_io_data_next   = r_buf[r_k];
        w_io_idx_next    = r_k;
        if (r_hold == 8'(HOLD - 1)) begin
          w_state_next = GAP;
          w_hold_next  = '0;
        end else begin
          w_hold_next = r_hold + 8'd1;
        end
      end
      GAP: begin
        // io_data/io_idx simply keep their value through the gap.
        w_io_active_next = 1'b1;
        if (r_k < 4'(NN - 1)) begin
          w_k_next     = r_k + 4'd1;
          w_hold_next  = '0;
          w_state_next = SHOW;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Cancel wins over everything except reset; the pulse is suppressed too.
    if (abort) begin
      w_state_next     = IDLE;
      w_k_next         = '0;
      w_hold_next      = '0;
      w_io_data_next   = '0;
      w_io_idx_next    = '0;
      w_io_en_next     = 1'b0;
      w_io_active_next = 1'b0;
      w_done_next      = 1'b0;
    end
  end

  assign io_data    = r_io_data;
  assign io_idx     = r_io_idx;
  assign io_en      = r_io_en;
  assign io_active  = r_io_active;
  assign done_pulse = r_done;

endmodule

// File: tb/tb_etpu_io_streamer.sv
// Directed bench for etpu_io_streamer. A frame-timeline model predicts every
// output each cycle from the number of clock edges since the last handshake;
// directed sections add hand-computed literal expectations.
module tb_etpu_io_streamer;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int HOLD  = 2;
  localparam int NN    = N * N;
  localparam int P     = HOLD + 1;     // cycles per word
  localparam int FL    = NN * P + 1;   // frame length, 49

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  res_valid = 1'b0;
  logic                  abort = 1'b0;
  logic [NN*ACC_W-1:0]   res_data = '0;
  logic                  res_ready;
  logic [15:0]           io_data;
  logic [3:0]            io_idx;
  logic                  io_en;
  logic                  io_active;
  logic                  done_pulse;

  int total = 0;
  int bad   = 0;

  etpu_io_streamer #(.N(N), .ACC_W(ACC_W), .HOLD(HOLD)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .abort     (abort),
    .io_data   (io_data),
    .io_idx    (io_idx),
    .io_en     (io_en),
    .io_active (io_active),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // ---------------- model: edges since handshake ----------------
  int          m_t = -1;     // -1: no frame; 0 = handshake edge just passed
  logic [15:0] m_buf [NN];
  logic [15:0] m_data = '0;
  logic [3:0]  m_idx  = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = -1; m_data = '0; m_idx = '0;
      end else begin
        if (abort) begin
          m_t = -1; m_data = '0; m_idx = '0;
        end else if ((m_t < 0 || m_t >= FL) && res_valid) begin
          for (int k = 0; k < NN; k++) m_buf[k] = sat(res_data[k*ACC_W +: ACC_W]);
          m_t = 0;
        end else if (m_t >= 0 && m_t < 1000) begin
          m_t++;
        end
        if (m_t >= 1 && m_t <= FL - 1) begin
          m_idx  = 4'((m_t - 1) / P);
          m_data = m_buf[m_idx];
        end
      end
    end
  end

  // ---------------- per-cycle compare on the falling edge ----------------
  initial begin
    logic e_en, e_act, e_done, e_rdy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_act  = (m_t >= 1 && m_t <= FL - 1);
        e_en   = e_act && (((m_t - 1) % P) < HOLD);
        e_done = (m_t == FL);
        e_rdy  = (m_t < 0 || m_t >= FL) && !abort;
        chk("cyc_io_en",     io_en,      e_en);
        chk("cyc_io_active", io_active,  e_act);
        chk("cyc_done",      done_pulse, e_done);
        chk("cyc_ready",     res_ready,  e_rdy);
        chk("cyc_io_idx",    io_idx,     m_idx);
        chk("cyc_io_data",   io_data,    m_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input int k, input logic [31:0] v);
    res_data[k*ACC_W +: ACC_W] = v;
  endtask

  task automatic handshake();
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] v, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (io_en && io_idx == v) found = 1;
      else tick();
    end
    chk(name, 32'(found), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, rises, en_cyc;
    logic prev_en;

    // Reset then idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready",  res_ready,  1);
    chk("rst_data",   io_data,    0);
    chk("rst_idx",    io_idx,     0);
    chk("rst_en",     io_en,      0);
    chk("rst_active", io_active,  0);
    chk("rst_done",   done_pulse, 0);
    tick();

    // Basic frame: word k = k+1
    for (int k = 0; k < NN; k++) set_word(k, 32'(k + 1));
    handshake();
    tick();
    chk("b_first_en",     io_en,     1);
    chk("b_first_active", io_active, 1);
    chk("b_first_idx",    io_idx,    0);
    chk("b_first_data",   io_data,   1);
    n = 1; rises = 0; en_cyc = 0; prev_en = 1'b0;
    while (!done_pulse && n < 100) begin
      if (io_en && !prev_en) begin
        chk("b_word_val", 32'(io_data), 32'(io_idx) + 1);
        chk("b_word_idx", 32'(io_idx), 32'(rises));
        rises++;
      end
      en_cyc += int'(io_en);
      prev_en = io_en;
      tick();
      n++;
    end
    chk("b_done_cycle", 32'(n), 32'd49);
    chk("b_rises",      32'(rises), 32'd16);
    chk("b_en_cycles",  32'(en_cyc), 32'd32);
    chk("b_done_idx",   io_idx, 15);
    chk("b_done_data",  io_data, 16);
    tick();
    chk("b_ready_after", res_ready, 1);
    chk("b_pulse_one",   done_pulse, 0);

    // Saturation
    res_data = '0;
    set_word(0, 32'h0001_2345);
    set_word(1, 32'hFFFF_0000);
    set_word(2, 32'hFFFF_FFFF);
    handshake();
    tick();
    chk("s_w0", io_data, 16'h7FFF);
    repeat (3) tick();
    chk("s_w1", io_data, 16'h8000);
    chk("s_w1_idx", io_idx, 1);
    repeat (3) tick();
    chk("s_w2", io_data, 16'hFFFF);
    repeat (45) tick();

    // Abort mid-frame
    for (int k = 0; k < NN; k++) set_word(k, 32'(k * 7 - 3));
    handshake();
    wait_idx(4'd5, "a_reach_idx5");
    abort = 1'b1;
    tick();
    chk("a_active", io_active,  0);
    chk("a_en",     io_en,      0);
    chk("a_idx",    io_idx,     0);
    chk("a_data",   io_data,    0);
    chk("a_done",   done_pulse, 0);
    chk("a_ready_low", res_ready, 0);
    abort = 1'b0;
    #1;
    chk("a_ready_back", res_ready, 1);
    handshake();
    tick();
    chk("a_restart_idx",  io_idx,  0);
    chk("a_restart_en",   io_en,   1);
    chk("a_restart_data", io_data, 16'hFFFD);
    repeat (50) tick();

    // Handshake rules: res_valid held across two frames, data changed mid-stream
    for (int k = 0; k < NN; k++) set_word(k, 32'(100 + k));
    res_valid = 1'b1;
    tick();                       // handshake edge T1
    repeat (10) tick();
    for (int k = 0; k < NN; k++) set_word(k, 32'(1000 + 3 * k));
    set_word(0, 32'h8000_0000);
    repeat (38) tick();           // T1+48: DONE state, no pulse visible yet
    chk("h_no_early_done", done_pulse, 0);
    tick();                       // T1+49
    chk("h_done",     done_pulse, 1);
    chk("h_last_val", io_data, 16'd115);
    tick();                       // T1+50: second handshake edge
    res_valid = 1'b0;
    chk("h_gap_active", io_active, 0);
    chk("h_gap_done",   done_pulse, 0);
    tick();                       // T1+51
    chk("h_b_en",   io_en,   1);
    chk("h_b_idx",  io_idx,  0);
    chk("h_b_data", io_data, 16'h8000);
    repeat (3) tick();
    chk("h_b_w1", io_data, 16'd1003);
    repeat (50) tick();

    // Asynchronous reset mid-frame
    for (int k = 0; k < NN; k++) set_word(k, 32'(k + 1));
    handshake();
    wait_idx(4'd9, "r_reach_idx9");
    rst = 1'b1;
    #1;
    chk("r_active", io_active,  0);
    chk("r_en",     io_en,      0);
    chk("r_idx",    io_idx,     0);
    chk("r_data",   io_data,    0);
    chk("r_done",   done_pulse, 0);
    rst = 1'b0;
    tick();
    chk("r_ready",       res_ready, 1);
    chk("r_idle_active", io_active, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
